branch_predictor: RTL and testbench

Fetch-stage dynamic branch predictor for the RV32I core: predicts taken/not-taken and target for the current fetch PC. It consumes the execute-stage resolution produced by the branch checker (its `yes` output) to train itself. It holds a direct-mapped table of 2-bit saturating counters and a tagged branch target buffer (BTB). It also reports mispredicts back to the pipeline for redirect.

---
 rtl/bp_pkg.sv | 22 ++
 rtl/sat_counter2.sv | 21 ++
 rtl/branch_predictor.sv | 103 ++++++++++
 tb/tb_branch_predictor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: 2-bit counter
// encoding and table geometry helpers.
package bp_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_SNT = 2'd0;
    localparam cnt_t CNT_WNT = 2'd1;
    localparam cnt_t CNT_WT  = 2'd2;
    localparam cnt_t CNT_ST  = 2'd3;
    localparam cnt_t CNT_RST = CNT_WNT;

    // Word-aligned PCs: two low bits are neither index nor tag.
    function automatic int tag_width(input int xlen, input int index_w);
        return xlen - index_w - 2;
    endfunction

    function automatic int table_depth(input int index_w);
        return 1 << index_w;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != CNT_ST)
                nxt = cur + 2'd1;
        end else begin
            if (cur != CNT_SNT)
                nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter table plus tagged BTB, trained at execute.
// Optional gshare counter indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int INDEX_W = 6,
    parameter int GHR_W   = INDEX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_f,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    input  logic [GHR_W-1:0] upd_ghr,
    output logic             mispredict
);

    localparam int DEPTH = table_depth(INDEX_W);
    localparam int TAG_W = tag_width(XLEN, INDEX_W);

    cnt_t              cnt_q     [DEPTH];
    logic              btb_v_q   [DEPTH];
    logic [TAG_W-1:0]  btb_tag_q [DEPTH];
    logic [XLEN-1:0]   btb_tgt_q [DEPTH];

    logic [INDEX_W-1:0] look_idx, upd_idx;
    logic [INDEX_W-1:0] look_cnt_idx, upd_cnt_idx;
    logic [TAG_W-1:0]   look_tag, upd_tag;
    cnt_t               cnt_nxt;

    assign look_idx = pc_f[INDEX_W+1:2];
    assign look_tag = pc_f[XLEN-1:INDEX_W+2];
    assign upd_idx  = upd_pc[INDEX_W+1:2];
    assign upd_tag  = upd_pc[XLEN-1:INDEX_W+2];

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;
    logic [1:0]       unused_bits;

    assign look_cnt_idx = look_idx ^ INDEX_W'(ghr_q);
    assign upd_cnt_idx  = upd_idx ^ INDEX_W'(upd_ghr);
    assign pred_ghr     = ghr_q;
    assign unused_bits  = pc_f[1:0] ^ upd_pc[1:0];

    // History is trained from resolved outcomes only, never speculatively.
    always_ff @(posedge clk) begin
        if (rst)
            ghr_q <= '0;
        else if (upd_valid)
            ghr_q <= {ghr_q[GHR_W-2:0], upd_taken};
    end
`else
    logic unused_bits;

    assign look_cnt_idx = look_idx;
    assign upd_cnt_idx  = upd_idx;
    assign pred_ghr     = '0;
    assign unused_bits  = ^{pc_f[1:0], upd_pc[1:0], upd_ghr};
`endif

    sat_counter2 u_sat (
        .cur   (cnt_q[upd_cnt_idx]),
        .taken (upd_taken),
        .nxt   (cnt_nxt)
    );

    always_comb begin
        pred_hit    = btb_v_q[look_idx] && (btb_tag_q[look_idx] == look_tag);
        pred_taken  = pred_hit && cnt_q[look_cnt_idx][1];
        pred_target = pred_hit ? btb_tgt_q[look_idx] : '0;
    end

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

    // Reset wins over a coincident update; tag/target need no reset behind valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i]   <= CNT_RST;
                btb_v_q[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            cnt_q[upd_cnt_idx] <= cnt_nxt;
            if (upd_taken) begin
                btb_v_q[upd_idx]   <= 1'b1;
                btb_tag_q[upd_idx] <= upd_tag;
                btb_tgt_q[upd_idx] <= upd_target;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a table-level reference model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_branch_predictor;

    localparam int XLEN = 32;
    localparam int IW   = 6;
    localparam int GW   = IW;
    localparam int N    = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     pc_f;
    logic            pred_hit, pred_taken;
    logic [31:0]     pred_target;
    logic [GW-1:0]   pred_ghr;
    logic            upd_valid, upd_taken, upd_pred_taken;
    logic [31:0]     upd_pc, upd_target, upd_pred_target;
    logic [GW-1:0]   upd_ghr;
    logic            mispredict;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: plain integer tables
    int          m_cnt [N];
    bit          m_v   [N];
    int unsigned m_tag [N];
    int unsigned m_tgt [N];
    int unsigned m_ghr;

    branch_predictor #(.XLEN(XLEN), .INDEX_W(IW), .GHR_W(GW)) dut (
        .clk(clk), .rst(rst), .pc_f(pc_f),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
        .mispredict(mispredict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned slot(input int unsigned pc);
        return (pc / 4) % N;
    endfunction

    function automatic int unsigned cslot(input int unsigned pc, input int unsigned h);
`ifdef BP_GSHARE_EN
        return ((pc / 4) % N) ^ (h % N);
`else
        return (pc / 4) % N;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 1;
                m_v[i]   = 1'b0;
            end
            m_ghr = 0;
        end else if (upd_valid === 1'b1) begin
            int unsigned ci, bi;
            ci = cslot(upd_pc, upd_ghr);
            bi = slot(upd_pc);
            if (upd_taken) m_cnt[ci] = (m_cnt[ci] >= 3) ? 3 : m_cnt[ci] + 1;
            else           m_cnt[ci] = (m_cnt[ci] <= 0) ? 0 : m_cnt[ci] - 1;
            if (upd_taken) begin
                m_v[bi]   = 1'b1;
                m_tag[bi] = upd_pc / 256;
                m_tgt[bi] = upd_target;
            end
`ifdef BP_GSHARE_EN
            m_ghr = ((m_ghr * 2) + (upd_taken ? 1 : 0)) % N;
`endif
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            bit          e_hit, e_tk, e_mp;
            int unsigned e_tgt, bi;
            bi     = slot(pc_f);
            e_hit  = m_v[bi] && (m_tag[bi] == pc_f / 256);
            e_tk   = e_hit && (m_cnt[cslot(pc_f, m_ghr)] >= 2);
            e_tgt  = e_hit ? m_tgt[bi] : 0;
            e_mp   = upd_valid && ((upd_taken != upd_pred_taken) ||
                     (upd_taken && upd_pred_taken && upd_target != upd_pred_target));
            chk("model_hit",    32'(pred_hit),   32'(e_hit));
            chk("model_taken",  32'(pred_taken), 32'(e_tk));
            chk("model_target", pred_target,     e_tgt);
            chk("model_ghr",    32'(pred_ghr),   m_ghr);
            chk("model_mispredict", 32'(mispredict), 32'(e_mp));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        pc_f = pc; upd_valid = 1'b0; #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] upc, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        pc_f = pc; upd_valid = 1'b1; upd_pc = upc; upd_taken = tk;
        upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
        upd_ghr = GW'(m_ghr);
        #1;
    endtask

    initial begin
        rst = 1'b1; pc_f = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0;
        upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0; upd_ghr = 0;
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        look(32'h100);
        chk("rst_hit", 32'(pred_hit), 0);
        chk("rst_taken", 32'(pred_taken), 0);
        chk("rst_target", pred_target, 0);
        chk("rst_ghr", 32'(pred_ghr), 0);
        chk("idle_mispredict", 32'(mispredict), 0);

        upd(32'h100, 32'h100, 1, 32'h80, 0, 0);
        chk("first_taken_mispredict", 32'(mispredict), 1);
        chk("no_bypass_hit", 32'(pred_hit), 0);
        tick();
        look(32'h100);
        chk("trained_hit", 32'(pred_hit), 1);
        chk("trained_taken", 32'(pred_taken), 1);
        chk("trained_target", pred_target, 32'h80);

        for (int i = 0; i < 3; i++) begin
            upd(32'h100, 32'h100, 1, 32'h80, 1, 32'h80);
            chk("correct_mispredict", 32'(mispredict), 0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            upd(32'h100, 32'h100, 0, 32'h0, 1, 32'h80);
            chk("nt_mispredict", 32'(mispredict), 1);
            tick();
        end
        look(32'h100);
        chk("after_nt_taken", 32'(pred_taken), 0);
        chk("after_nt_hit", 32'(pred_hit), 1);

        upd(32'h100, 32'h100, 1, 32'h80, 0, 0);      tick();
        upd(32'h200, 32'h200, 1, 32'h300, 0, 0);     tick();
        look(32'h100);
        chk("alias_old_hit", 32'(pred_hit), 0);
        look(32'h200);
        chk("alias_new_hit", 32'(pred_hit), 1);
        chk("alias_new_target", pred_target, 32'h300);
        tick();

        upd(32'h104, 32'h104, 1, 32'h500, 0, 0);
        chk("same_cycle_hit", 32'(pred_hit), 0);
        tick();
        look(32'h104);
        chk("next_cycle_hit", 32'(pred_hit), 1);
        chk("next_cycle_target", pred_target, 32'h500);

        // Not-taken never allocates a BTB entry
        upd(32'h0, 32'h110, 0, 32'h0, 0, 0);
        chk("nt_correct_mispredict", 32'(mispredict), 0);
        tick();
        look(32'h110);
        chk("nt_no_alloc", 32'(pred_hit), 0);

        upd(32'h108, 32'h108, 1, 32'h80, 1, 32'h40);
        chk("target_mismatch", 32'(mispredict), 1);
        tick();
`ifdef BP_GSHARE_EN
        look(32'h108);
        chk("ghr_shift_lsb", 32'(pred_ghr[0]), 1);
`endif

        // Drive counter at 0x104 into strong-NT, then one taken -> still NT
        for (int i = 0; i < 4; i++) begin
            upd(32'h0, 32'h104, 0, 32'h0, 0, 0); tick();
        end
        upd(32'h0, 32'h104, 1, 32'h500, 0, 0); tick();
        look(32'h104);
        chk("sat_zero_taken", 32'(pred_taken), 0);
        chk("sat_zero_hit", 32'(pred_hit), 1);

        // Mixed directed traffic over a few aliasing PCs
        for (int i = 0; i < 40; i++) begin
            logic [31:0] pcs [4];
            pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h104; pcs[3] = 32'h1104;
            upd(pcs[i % 4], pcs[(i * 3) % 4], logic'((i % 3) != 0), 32'h1000 + 32'(i * 4),
                logic'(i % 2), 32'h1000 + 32'(i * 4));
            tick();
        end

        // Reset beats a coincident update
        rst = 1'b1;
        upd(32'h10c, 32'h10c, 1, 32'h90, 0, 0);
        tick();
        rst = 1'b0;
        look(32'h10c);
        chk("rst_discards_update", 32'(pred_hit), 0);
        look(32'h200);
        chk("rst_clears_btb", 32'(pred_hit), 0);
        chk("rst_clears_ghr", 32'(pred_ghr), 0);
        tick();
        look(32'h100);
        tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
